// File: rtl/axis_reg_fifo.sv
// DEPTH-entry register-based AXI-Stream buffer carrying tdata/tlast, with occupancy
// counters and an optional store-and-forward packet mode.
module axis_reg_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter bit          PKT_MODE   = 1'b0
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic [$clog2(DEPTH):0]    fill_level,
    output logic [$clog2(DEPTH):0]    pkt_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_last;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_fill;
    logic [CW-1:0]         r_pkt;
    logic                  r_flush;
    logic                  r_s_ready;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_push_last;
    logic                  w_pop_last;
    logic [AW-1:0]         w_wr_nxt;
    logic [AW-1:0]         w_rd_nxt;
    logic [CW-1:0]         w_fill_nxt;
    logic [CW-1:0]         w_pkt_nxt;
    logic                  w_flush_nxt;
    logic                  w_valid_nxt;
    logic                  w_bypass;

    // Next-state for pointers, counters, flush and the registered handshake outputs
    always_comb begin
        w_push      = s_axis_tvalid && r_s_ready;
        w_pop       = r_m_valid && m_axis_tready;
        w_push_last = w_push && s_axis_tlast;
        w_pop_last  = w_pop && r_last[r_rd_ptr];
        w_wr_nxt    = w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
        w_rd_nxt    = w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;

        w_fill_nxt = r_fill;
        if (w_push && !w_pop) begin
            w_fill_nxt = r_fill + CW'(1);
        end else if (!w_push && w_pop) begin
            w_fill_nxt = r_fill - CW'(1);
        end

        w_pkt_nxt = r_pkt;
        if (w_push_last && !w_pop_last) begin
            w_pkt_nxt = r_pkt + CW'(1);
        end else if (!w_push_last && w_pop_last) begin
            w_pkt_nxt = r_pkt - CW'(1);
        end

        // Full with no complete packet would deadlock, so start draining the partial packet
        w_flush_nxt = r_flush;
        if (w_pop_last) begin
            w_flush_nxt = 1'b0;
        end else if ((r_fill == CW'(DEPTH)) && (r_pkt == '0)) begin
            w_flush_nxt = 1'b1;
        end

        w_valid_nxt = (w_fill_nxt != '0) &&
                      (!PKT_MODE || (w_pkt_nxt != '0) || w_flush_nxt);

        // Head slot is the one being written this edge (empty, or one entry popped)
        w_bypass = w_push && (r_wr_ptr == w_rd_nxt);
    end

    // Storage array: written on push, contents irrelevant after reset
    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= s_axis_tdata;
            r_last[r_wr_ptr] <= s_axis_tlast;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_fill    <= '0;
            r_pkt     <= '0;
            r_flush   <= 1'b0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_nxt;
            r_rd_ptr  <= w_rd_nxt;
            r_fill    <= w_fill_nxt;
            r_pkt     <= w_pkt_nxt;
            r_flush   <= w_flush_nxt;
            r_s_ready <= (w_fill_nxt != CW'(DEPTH));
            r_m_valid <= w_valid_nxt;
            r_m_data  <= w_bypass ? s_axis_tdata : r_data[w_rd_nxt];
            r_m_last  <= w_bypass ? s_axis_tlast : r_last[w_rd_nxt];
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign fill_level    = r_fill;
    assign pkt_count     = r_pkt;

endmodule

// File: tb/tb_axis_reg_fifo.sv
// Bench for axis_reg_fifo: a stream-mode and a packet-mode instance share stimulus
// and are compared each cycle against a list-based model of buffer contents.
module tb_axis_reg_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          m_tready = 1'b0;

    logic          s_rdy  [2];
    logic          m_vld  [2];
    logic [DW-1:0] m_dat  [2];
    logic          m_lst  [2];
    logic [CW-1:0] fill   [2];
    logic [CW-1:0] pktc   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: ordered list of {tlast,tdata} per instance (index 0 = stream, 1 = packet)
    logic [8:0] mq [2][DEPTH];
    int         msz [2];
    bit         mflush [2];
    bit         mrun = 1'b0;
    bit         mstarted = 1'b0;
    bit         mrst_edge = 1'b0;
    bit         pushed [2];

    always #5 aclk = ~aclk;

    axis_reg_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(1'b0)) u_dut_s (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_rdy[0]),
        .m_axis_tdata(m_dat[0]), .m_axis_tvalid(m_vld[0]), .m_axis_tlast(m_lst[0]),
        .m_axis_tready(m_tready),
        .fill_level(fill[0]), .pkt_count(pktc[0])
    );

    axis_reg_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(1'b1)) u_dut_p (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_rdy[1]),
        .m_axis_tdata(m_dat[1]), .m_axis_tvalid(m_vld[1]), .m_axis_tlast(m_lst[1]),
        .m_axis_tready(m_tready),
        .fill_level(fill[1]), .pkt_count(pktc[1])
    );

    function automatic int lasts(input int k);
        int n = 0;
        for (int i = 0; i < msz[k]; i++) n += int'(mq[k][i][8]);
        return n;
    endfunction

    function automatic bit exp_rdy(input int k);
        return mrun && (msz[k] != DEPTH);
    endfunction

    function automatic bit exp_vld(input int k);
        return (msz[k] != 0) && ((k == 0) || (lasts(k) != 0) || mflush[k]);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit pu [2];
        bit po [2];
        bit full_nolast [2];
        bit pop_last [2];
        for (int k = 0; k < 2; k++) begin
            pu[k]          = s_tvalid && exp_rdy(k);
            po[k]          = m_tready && exp_vld(k);
            full_nolast[k] = (msz[k] == DEPTH) && (lasts(k) == 0);
            pop_last[k]    = po[k] && mq[k][0][8];
        end
        for (int k = 0; k < 2; k++) begin
            if (areset) begin
                msz[k]    = 0;
                mflush[k] = 1'b0;
                pushed[k] = 1'b0;
            end else begin
                if (po[k]) begin
                    for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
                    msz[k]--;
                end
                if (pu[k]) begin
                    mq[k][msz[k]] = {s_tlast, s_tdata};
                    msz[k]++;
                end
                if (pop_last[k]) mflush[k] = 1'b0;
                else if (full_nolast[k]) mflush[k] = 1'b1;
                pushed[k] = pu[k];
            end
        end
        mrst_edge = areset;
        mrun      = !areset;
        mstarted  = 1'b1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("s_tready", k, 32'(s_rdy[k]), 32'(exp_rdy(k)));
            chk("m_tvalid", k, 32'(m_vld[k]), 32'(exp_vld(k)));
            chk("fill_level", k, 32'(fill[k]), 32'(msz[k]));
            chk("pkt_count", k, 32'(pktc[k]), 32'(lasts(k)));
            if (mrst_edge) begin
                chk("rst_tdata", k, 32'(m_dat[k]), 32'(0));
                chk("rst_tlast", k, 32'(m_lst[k]), 32'(0));
            end else if (exp_vld(k)) begin
                chk("m_tdata", k, 32'(m_dat[k]), 32'(mq[k][0][7:0]));
                chk("m_tlast", k, 32'(m_lst[k]), 32'(mq[k][0][8]));
            end
        end
    endtask

    // One clock: drive at negedge, confirm tvalid ignores the new tready, then check after the edge
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r, input logic rst);
        @(negedge aclk);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        areset   = rst;
        #1;
        if (mstarted) begin
            for (int k = 0; k < 2; k++) chk("tvalid_no_comb", k, 32'(m_vld[k]), 32'(exp_vld(k)));
        end
        @(posedge aclk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0] seq [4];
        logic [7:0] pk  [3];
        int idx;
        int cyc;

        for (int k = 0; k < 2; k++) begin
            msz[k] = 0;
            mflush[k] = 1'b0;
            pushed[k] = 1'b0;
        end

        // Reset and idle
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_tready", 0, 32'(s_rdy[0]), 32'(0));
        chk("reset_tvalid", 0, 32'(m_vld[0]), 32'(0));
        chk("reset_fill", 0, 32'(fill[0]), 32'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_reset_tready", 0, 32'(s_rdy[0]), 32'(1));

        // Fill to full with downstream stalled, then drain in order
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0, 1'b0, 1'b0);
        chk("full_fill", 0, 32'(fill[0]), 32'(4));
        chk("full_tready", 0, 32'(s_rdy[0]), 32'(0));
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 0, 32'(m_dat[0]), 32'(seq[i]));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            if (i == 0) chk("tready_after_pop", 0, 32'(s_rdy[0]), 32'(1));
        end
        repeat (6) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Continuous streaming with both sides ready
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), (i == 15), 1'b1, 1'b0);
            chk("stream_data", 0, 32'(m_dat[0]), 32'(i));
            chk("stream_fill", 0, 32'(fill[0]), 32'(1));
        end
        repeat (8) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure: downstream ready toggles every cycle
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 64) begin
            step(1'b1, 8'hC0 + 8'(idx), (idx == 7), 1'(cyc % 2), 1'b0);
            if (pushed[0]) idx++;
            cyc++;
        end
        chk("bp_all_pushed", 0, 32'(idx), 32'(8));
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Packet mode: output withheld until the tlast beat is stored
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        pk[0] = 8'hA1; pk[1] = 8'hA2; pk[2] = 8'hA3;
        step(1'b1, pk[0], 1'b0, 1'b1, 1'b0);
        chk("pkt_hold_1", 1, 32'(m_vld[1]), 32'(0));
        step(1'b1, pk[1], 1'b0, 1'b1, 1'b0);
        chk("pkt_hold_2", 1, 32'(m_vld[1]), 32'(0));
        step(1'b1, pk[2], 1'b1, 1'b1, 1'b0);
        chk("pkt_release", 1, 32'(m_vld[1]), 32'(1));
        chk("pkt_count_1", 1, 32'(pktc[1]), 32'(1));
        for (int i = 0; i < 3; i++) begin
            chk("pkt_order", 1, 32'(m_dat[1]), 32'(pk[i]));
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("pkt_count_0", 1, 32'(pktc[1]), 32'(0));
        chk("pkt_done_tvalid", 1, 32'(m_vld[1]), 32'(0));

        // Oversize packet forces flush; all six beats must emerge
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 64) begin
            step(1'b1, 8'hB0 + 8'(idx), (idx == 5), 1'b1, 1'b0);
            if (pushed[1]) idx++;
            cyc++;
        end
        chk("oversize_pushed", 1, 32'(idx), 32'(6));
        repeat (8) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("oversize_drained", 1, 32'(fill[1]), 32'(0));
        step(1'b1, 8'hE0, 1'b0, 1'b1, 1'b0);
        chk("flush_cleared", 1, 32'(m_vld[1]), 32'(0));
        step(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hE3, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("mid_drain_rst_fill", 1, 32'(fill[1]), 32'(0));
        chk("mid_drain_rst_tvalid", 1, 32'(m_vld[1]), 32'(0));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
